// File: rtl/cpu_bus_mem.sv
// cpu_bus_mem: byte-wide bus memory slave, read acks after WAIT_STATES waits.
// Optional CPU_MEM_WRPROT_EN: drop writes at/above WRPROT_BASE, flag wr_fault.
module cpu_bus_mem #(
   parameter int          ADDR_BITS   = 12,
   parameter int          WAIT_STATES = 1,
   parameter logic [15:0] WRPROT_BASE = 16'hF000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] bus_addr,
   input  logic [7:0]  wr_data,
   input  logic        wr_enable,
   input  logic        rd_req,
   output logic [7:0]  rd_data,
   output logic        rd_ack,
   output logic        busy,
   output logic        wr_fault
);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t               state;
   logic [3:0]           wait_cnt;
   logic [ADDR_BITS-1:0] rd_addr;
   logic [7:0]           mem [2**ADDR_BITS];
   logic                 wr_ok;
   logic                 unused_bits;

   if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
      $error("cpu_bus_mem: WAIT_STATES must be 0..15");
   end

`ifdef CPU_MEM_WRPROT_EN
   assign wr_ok = (bus_addr < WRPROT_BASE);

   // Sticky flag raised by any write into the protected window
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         wr_fault <= 1'b0;
      else if (wr_enable && !wr_ok)
         wr_fault <= 1'b1;
   end
`else
   assign wr_ok    = 1'b1;
   assign wr_fault = 1'b0;
`endif

   // Upper address bits alias; base only matters when protection is built in
   assign unused_bits = ^{bus_addr[15:ADDR_BITS], WRPROT_BASE};

   // Posted byte writes, independent of the read FSM; array is never reset
   always_ff @(posedge clk) begin
      if (wr_enable && wr_ok)
         mem[bus_addr[ADDR_BITS-1:0]] <= wr_data;
   end

   // Read FSM: latch address in IDLE, count waits, then one-cycle ack
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         wait_cnt <= '0;
         rd_addr  <= '0;
         rd_data  <= 8'h00;
         rd_ack   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               rd_ack <= 1'b0;
               if (rd_req) begin
                  rd_addr  <= bus_addr[ADDR_BITS-1:0];
                  wait_cnt <= 4'(WAIT_STATES);
                  state    <= WAIT;
                  busy     <= 1'b1;
               end
            end
            WAIT: begin
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end else begin
                  rd_data <= mem[rd_addr];
                  rd_ack  <= 1'b1;
                  state   <= ACK;
               end
            end
            ACK: begin
               rd_ack <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               rd_ack <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
